// File: rtl/serial_adder_ctrl_pkg.sv
// Types for the bit-serial adder controller; state values come from
// serial_adder_defs.vh so every consumer agrees on the encoding.
package serial_adder_ctrl_pkg;
`include "serial_adder_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE  = `SA_STATE_IDLE,
    ST_SHIFT = `SA_STATE_SHIFT,
    ST_DONE  = `SA_STATE_DONE
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full-adder cell: purely combinational, holds no state.
module serial_adder_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_defs.vh
// State encodings shared by the serial adder controller and anything that
// inspects its state (debug port, bench).
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
`define SA_STATE_IDLE  2'd0
`define SA_STATE_SHIFT 2'd1
`define SA_STATE_DONE  2'd2
`endif

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer around one full-adder cell, LSB first.
// Optional subtract mode (Sub input, Ovf output) under SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
  output logic             Ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshake: start is accepted only in IDLE or DONE; an accepted start
  // captures A/B/Cin that edge, busy stays high for WIDTH cycles, then done
  // pulses for exactly one cycle with Sum/Cout valid until the next accept.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cell_s, cell_c;
  logic             accept, last_bit, sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = Sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign dbg_state = state_q;

  serial_adder_ctrl_fa u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Subtract is A + ~B + 1: invert B on capture and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= sub_sel ? ~B : B;
      res_q   <= '0;
      carry_q <= sub_sel ? 1'b1 : Cin;
      cnt_q   <= '0;
    end else if (state_q == ST_SHIFT) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= {cell_s, res_q[WIDTH-1:1]};
      carry_q <= cell_c;
      cnt_q   <= last_bit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Result outputs load only on the final bit so they never show partial sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      Sum  <= '0;
      Cout <= 1'b0;
    end else if ((state_q == ST_SHIFT) && last_bit) begin
      Sum  <= {cell_s, res_q[WIDTH-1:1]};
      Cout <= cell_c;
    end
  end

`ifdef SERIAL_ADDER_SUB_EN
  // Signed overflow: carry into the MSB (carry_q on the last bit) vs carry out.
  always_ff @(posedge clk) begin
    if (reset)                                 Ovf <= 1'b0;
    else if ((state_q == ST_SHIFT) && last_bit) Ovf <= carry_q ^ cell_c;
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8), reference model uses
// plain integer arithmetic; define SERIAL_ADDER_SUB_EN to cover subtraction.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub, ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .A         (a),
    .B         (b),
    .Cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub       (sub),
    .Ovf       (ovf),
`endif
    .busy      (busy),
    .done      (done),
    .Sum       (sum),
    .Cout      (cout),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Returns {ovf, cout, sum} from integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    int ua, ub, sa, sb, r_u, r_s;
    logic co, ov;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (ms) begin
      r_u = ua - ub;
      co  = (ua >= ub);
      r_s = sa - sb;
    end else begin
      r_u = ua + ub + int'(mc);
      co  = (r_u >= (1 << W));
      r_s = sa + sb + int'(mc);
    end
    ov = (r_s > (1 << (W - 1)) - 1) || (r_s < -(1 << (W - 1)));
    return {ov, co, r_u[W-1:0]};
  endfunction

  task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic tc, input logic ts);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`else
    if (ts) $display("note: subtract requested without SERIAL_ADDER_SUB_EN");
`endif
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input logic ts, input string name);
    logic [W+1:0] exp;
    int cyc;
    bit seen;
    exp_q.push_back(model(ta, tb_v, tc, ts));
    drive_start(ta, tb_v, tc, ts);
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom_range(0, 1));
`endif
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (cyc != W + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, W + 1);
    end
    n_checks++;
    if (sum !== exp[W-1:0] || cout !== exp[W]) begin
      n_fail++;
      $display("FAIL %s result: got Sum=%h Cout=%b, expected Sum=%h Cout=%b",
               name, sum, cout, exp[W-1:0], exp[W]);
    end
`ifdef SERIAL_ADDER_SUB_EN
    n_checks++;
    if (ovf !== exp[W+1]) begin
      n_fail++;
      $display("FAIL %s ovf: got %b, expected %b", name, ovf, exp[W+1]);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b Sum=%h Cout=%b state=%0d, expected 0 0 00 0 %0d",
               busy, done, sum, cout, dbg_state, ST_IDLE);
    end
`ifdef SERIAL_ADDER_SUB_EN
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b, expected 0", ovf);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_timing();
    logic [W+1:0] exp;
    exp = model(8'h0F, 8'h01, 1'b0, 1'b0);
    drive_start(8'h0F, 8'h01, 1'b0, 1'b0);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (k <= W) begin
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00 || dbg_state !== ST_SHIFT) begin
          n_fail++;
          $display("FAIL timing_shift cycle T+%0d: busy=%b done=%b Sum=%h state=%0d, expected 1 0 00 %0d",
                   k, busy, done, sum, dbg_state, ST_SHIFT);
        end
      end else if (k == W + 1) begin
        if (busy !== 1'b0 || done !== 1'b1 || sum !== exp[W-1:0] || cout !== exp[W] ||
            dbg_state !== ST_DONE) begin
          n_fail++;
          $display("FAIL timing_done cycle T+%0d: busy=%b done=%b Sum=%h Cout=%b, expected 0 1 %h %b",
                   k, busy, done, sum, cout, exp[W-1:0], exp[W]);
        end
      end else begin
        if (done !== 1'b0 || busy !== 1'b0 || sum !== exp[W-1:0] || dbg_state !== ST_IDLE) begin
          n_fail++;
          $display("FAIL timing_after cycle T+%0d: done=%b busy=%b Sum=%h, expected 0 0 %h",
                   k, done, busy, sum, exp[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_carry();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, "carry_wrap");
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, "carry_full");
  endtask

  task automatic test_ignore_start();
    logic [W+1:0] exp;
    logic [W-1:0] got_sum;
    int cyc, done_cyc, pulses;
    exp = model(8'h12, 8'h34, 1'b0, 1'b0);
    drive_start(8'h12, 8'h34, 1'b0, 1'b0);
    done_cyc = 0; pulses = 0; got_sum = '0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (done_cyc == 0) begin done_cyc = cyc; got_sum = sum; end
      end
      if (cyc == 3) begin start = 1'b1; a = 8'hAA; end
      if (cyc == 4) start = 1'b0;
    end
    n_checks++;
    if (done_cyc != W + 1 || pulses != 1 || got_sum !== exp[W-1:0]) begin
      n_fail++;
      $display("FAIL ignore_start: done at T+%0d (%0d pulses) Sum=%h, expected T+%0d (1 pulse) Sum=%h",
               done_cyc, pulses, got_sum, W + 1, exp[W-1:0]);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    drive_start(8'h55, 8'h0A, 1'b0, 1'b0);
    pulses = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (done) pulses++;
      if (cyc == 5) begin
        n_checks++;
        if (busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || dbg_state !== ST_IDLE) begin
          n_fail++;
          $display("FAIL reset_mid_state: busy=%b Sum=%h Cout=%b state=%0d, expected 0 00 0 %0d",
                   busy, sum, cout, dbg_state, ST_IDLE);
        end
        reset = 1'b0;
      end
      if (cyc == 4) reset = 1'b1;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid_done: got %0d done pulses, expected 0", pulses);
    end
    do_op(8'h55, 8'h0A, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int d1, d2, pulses;
    logic [W-1:0] s1, s2;
    logic [W+1:0] e1, e2;
    e1 = model(8'h01, 8'h01, 1'b0, 1'b0);
    e2 = model(8'h02, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    d1 = 0; d2 = 0; pulses = 0; s1 = '0; s2 = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (d1 == 0) begin d1 = cyc; s1 = sum; end
        else if (d2 == 0) begin d2 = cyc; s2 = sum; end
      end
      if (cyc == 1) begin a = 8'h02; b = 8'h02; end
      if (cyc == W + 2) start = 1'b0;
    end
    n_checks++;
    if (d1 != W + 1 || d2 != 2 * (W + 1) || pulses != 2) begin
      n_fail++;
      $display("FAIL b2b_timing: done at T+%0d and T+%0d (%0d pulses), expected T+%0d and T+%0d",
               d1, d2, pulses, W + 1, 2 * (W + 1));
    end
    n_checks++;
    if (s1 !== e1[W-1:0] || s2 !== e2[W-1:0]) begin
      n_fail++;
      $display("FAIL b2b_result: got %h then %h, expected %h then %h", s1, s2, e1[W-1:0], e2[W-1:0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, "random_add");
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    do_op(8'h05, 8'h07, 1'b0, 1'b1, "sub_borrow");
    do_op(8'h80, 8'h01, 1'b1, 1'b1, "sub_ovf");
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
    for (int i = 0; i < 12; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            "random_mixed");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_carry();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
